// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction prefetch stage
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous in-order FIFO with clear, simultaneous push/pop and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DATA_W = 2 * WORD_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction prefetch with in-order buffering and redirect flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              empty,
  output logic              full
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [1:0]       MAX_OUTST_W = 2'(MAX_OUTST);
  localparam logic [OCC_W-1:0] DEPTH_W     = OCC_W'(DEPTH);

  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] resp_pc;
  logic [1:0]        outst;
  logic [1:0]        drop;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occupancy;
  logic              fifo_empty;
  logic              resp_valid;
  logic              resp_keep;
  logic              issue;
  logic              pop;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  // Responses with nothing in flight are stray (e.g. left over from before a reset).
  assign resp_valid = imem_rvalid && (outst != 2'd0);
  assign resp_keep  = resp_valid && !redirect && (drop == 2'd0);

  // Every in-flight request owns a queue slot, so a kept response can never overflow.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(outst);
  assign issue     = !reset && !redirect && (outst < MAX_OUTST_W) && (occupancy < DEPTH_W);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= 2'd0;
      drop     <= 2'd0;
    end else begin
      outst <= outst + 2'(issue) - 2'(resp_valid);
      if (redirect) begin
        fetch_pc <= align_word(redirect_pc);
        resp_pc  <= align_word(redirect_pc);
        // outst already counts earlier stale requests, so all still in flight become stale.
        drop     <= outst - 2'(resp_valid);
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp_valid) begin
          if (drop != 2'd0) begin
            drop <= drop - 2'd1;
          end else begin
            resp_pc <= resp_pc + 32'd4;
          end
        end
      end
    end
  end

  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (full)
  );

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? head.instr : INSTR_NOP;
  assign out_pc    = out_valid ? head.pc : '0;
  assign empty     = fifo_empty;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue with an in-order memory model
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        empty;
  logic        full;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];

  fetch_queue #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  // Memory: returns address as data, in order, mem_lat cycles after the request.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend[0].addr;
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      #1;
      if (reset === 1'b1) pend.delete();
      else if (imem_req === 1'b1) pend.push_back('{imem_addr, cyc + mem_lat});
      checks++;
      if (pend.size() > 2) begin
        failures++;
        $display("FAIL max_outstanding actual=%0d expected<=2", pend.size());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%b expected=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr actual=%h expected=0", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b expected=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_instr actual=%h expected=0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_pc actual=%h expected=0", out_pc); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty actual=%b expected=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full actual=%b expected=0", full); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req actual=%b expected=1", imem_req); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic        exp_v;
    exp_pc = 32'h0;
    mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      exp_v = (c >= 2);
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL stream_valid c=%0d actual=%b expected=%b", c, out_valid, exp_v); end
      if (c >= 2) begin
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL stream_pc c=%0d actual=%h expected=%h", c, out_pc, exp_pc); end
        checks++; if (out_instr !== exp_pc) begin failures++; $display("FAIL stream_instr c=%0d actual=%h expected=%h", c, out_instr, exp_pc); end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1;
    do_reset();
    out_ready = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL bp_full actual=%b expected=1", full); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL bp_head actual=%h expected=0", out_pc); end
    checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL bp_addr actual=%h expected=10", imem_addr); end
    out_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stop actual=%b expected=0", imem_req); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid i=%0d actual=%b expected=1", i, out_valid); end
      checks++; if (out_pc !== 32'(i * 4)) begin failures++; $display("FAIL bp_drain_pc i=%0d actual=%h expected=%h", i, out_pc, 32'(i * 4)); end
    end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL bp_not_full actual=%b expected=0", full); end
  endtask

  task automatic test_redirect_inflight();
    int first;
    first = -1;
    mem_lat = 3;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rd_no_issue actual=%b expected=0", imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_flushed actual=%b expected=0", out_valid); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rd_addr actual=%h expected=100", imem_addr); end
    for (int c = 4; c <= 20 && first < 0; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) first = c;
    end
    checks++; if (first !== 8) begin failures++; $display("FAIL rd_first_cycle actual=%0d expected=8", first); end
    checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL rd_first_pc actual=%h expected=100", out_pc); end
    checks++; if (out_instr !== 32'h100) begin failures++; $display("FAIL rd_first_instr actual=%h expected=100", out_instr); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h104) begin failures++; $display("FAIL rd_second_pc actual=%h expected=104", out_pc); end
  endtask

  task automatic test_redirect_pop_resp();
    mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL rpr_head actual=%h expected=4", out_pc); end
    checks++; if (imem_rvalid !== 1'b1) begin failures++; $display("FAIL rpr_resp_present actual=%b expected=1", imem_rvalid); end
    redirect = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rpr_valid actual=%b expected=0", out_valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rpr_empty actual=%b expected=1", empty); end
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rpr_req actual=%b expected=1", imem_req); end
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rpr_aligned_addr actual=%h expected=200", imem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rpr_gap actual=%b expected=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rpr_new_valid actual=%b expected=1", out_valid); end
    checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL rpr_new_pc actual=%h expected=200", out_pc); end
  endtask

  task automatic test_reset_midstream();
    mem_lat = 1;
    do_reset();
    out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid actual=%b expected=1", out_valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL mid_pre_full actual=%b expected=0", full); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid actual=%b expected=0", out_valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_empty actual=%b expected=1", empty); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mid_addr actual=%h expected=0", imem_addr); end
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_restart_req actual=%b expected=1", imem_req); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_restart_valid actual=%b expected=1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL mid_restart_pc actual=%h expected=0", out_pc); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL mid_restart_pc2 actual=%h expected=4", out_pc); end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    do_reset();
    out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_no_issue actual=%b expected=0", imem_req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 actual=%h expected=fffffffc", imem_addr); end
    @(negedge clk);
    #1;
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 actual=%h expected=0", imem_addr); end
    @(negedge clk);
    checks++; if (out_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc0 actual=%h expected=fffffffc", out_pc); end
    checks++; if (out_instr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_instr0 actual=%h expected=fffffffc", out_instr); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h0 || out_valid !== 1'b1) begin failures++; $display("FAIL wrap_pc1 actual=%h/%b expected=0/1", out_pc, out_valid); end
    @(negedge clk);
    checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL wrap_pc2 actual=%h expected=4", out_pc); end
  endtask

  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop_resp();
    test_reset_midstream();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
